// File: rtl/gyrator_pkg.sv
// gyrator_pkg: shared state encoding and defaults for the gyrator tuning controller.
// rev 1.0
`default_nettype none

package gyrator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DECIDE  = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  localparam int DEF_TRIM_W     = 6;
  localparam int DEF_GATE_W     = 12;
  localparam int DEF_CNT_W      = 10;
  localparam int DEF_SETTLE_CYC = 16;
  localparam int SYNC_DEPTH     = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gyrator_edge_cnt.sv
// gyrator_edge_cnt: comparator synchroniser, rising-edge detect and saturating edge counter.
// rev 1.0
`default_nettype none

module gyrator_edge_cnt
  import gyrator_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmp_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [SYNC_DEPTH-1:0] sync;
  logic                  sync_prev;
  logic                  rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_DEPTH-2:0], cmp_in};
      sync_prev <= sync[SYNC_DEPTH-1];
    end
  end

  assign rise = sync[SYNC_DEPTH-1] & ~sync_prev;

  // Saturate at all-ones so an over-fast oscillator never reads as a slow one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && rise && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gyrator_tune.sv
// gyrator_tune: SAR loop choosing the largest trim code whose edge count stays at or below target.
// rev 1.0
`default_nettype none

module gyrator_tune
  import gyrator_pkg::*;
#(
  parameter int TRIM_W     = DEF_TRIM_W,
  parameter int GATE_W     = DEF_GATE_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [CNT_W-1:0]  target,
  input  logic              cmp_in,
  output logic [TRIM_W-1:0] trim,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic [CNT_W-1:0]  meas
);

  localparam int K_W   = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam int TMR_W = max_int(GATE_W, $clog2(SETTLE_CYC + 1));
  localparam logic [TRIM_W-1:0] MIDSCALE = TRIM_W'(1) << (TRIM_W - 1);

  state_t             state;
  state_t             state_nx;
  logic [TMR_W-1:0]   tmr;
  logic               tmr_zero;
  logic [GATE_W-1:0]  gate_m1;
  logic [CNT_W-1:0]   target_q;
  logic [K_W-1:0]     k;
  logic [TRIM_W-1:0]  trim_dec;
  logic [CNT_W-1:0]   count;
  logic               cnt_clr;
  logic               cnt_en;

  gyrator_edge_cnt #(
    .CNT_W (CNT_W)
  ) u_edge_cnt (
    .clk    (clk),
    .rst    (rst),
    .cmp_in (cmp_in),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .count  (count)
  );

  assign tmr_zero = (tmr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy    = 1'b1;
        cnt_clr = 1'b1;
        if (tmr_zero) state_nx = ST_MEASURE;
      end
      ST_MEASURE: begin
        busy   = 1'b1;
        cnt_en = 1'b1;
        if (tmr_zero) state_nx = ST_DECIDE;
      end
      ST_DECIDE: begin
        busy     = 1'b1;
        state_nx = (k == '0) ? ST_FINISH : ST_SETTLE;
      end
      ST_FINISH: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Higher trim means higher frequency: an over-target count drops the bit under test.
  always_comb begin
    trim_dec = trim;
    if (count > target_q) trim_dec[k] = 1'b0;
    if (k != '0) trim_dec[k - 1'b1] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trim     <= '0;
      meas     <= '0;
      locked   <= 1'b0;
      k        <= '0;
      tmr      <= '0;
      gate_m1  <= '0;
      target_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            gate_m1  <= (gate_len == '0) ? '0 : gate_len - 1'b1;
            target_q <= target;
            trim     <= MIDSCALE;
            k        <= K_W'(TRIM_W - 1);
            locked   <= 1'b0;
            tmr      <= TMR_W'(SETTLE_CYC - 1);
          end
        end
        ST_SETTLE: begin
          tmr <= tmr_zero ? TMR_W'(gate_m1) : tmr - 1'b1;
        end
        ST_MEASURE: begin
          if (!tmr_zero) tmr <= tmr - 1'b1;
        end
        ST_DECIDE: begin
          meas <= count;
          trim <= trim_dec;
          tmr  <= TMR_W'(SETTLE_CYC - 1);
          if (k != '0) k <= k - 1'b1;
        end
        ST_FINISH: begin
          locked <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/gyrator_tune.md
# gyrator_tune

Digital tuning controller for the Nauta-transconductor gyrator resonator. It drives a binary trim code into the gyrator bias generator and reads back the resonator's comparator output. A successive-approximation (SAR) loop, one bit per measurement window, finds the trim code whose oscillation edge count is closest to and not above a programmed target. It sits between the configuration registers and the analog bias/trim DAC, as the return path of the bias/injector chain.

## Interface

- `TRIM_W`, 6: trim code width, number of SAR iterations.
- `GATE_W`, 12: width of the measurement-window length.
- `CNT_W`, 10: edge-counter width.
- `SETTLE_CYC`, 16: analog settle cycles after each trim change, ≥1.
- `clk` in 1: single block clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin calibration. Sampled only in IDLE.
- `gate_len` in GATE_W: measurement window in clk cycles. Latched at start; 0 is treated as 1.
- `target` in CNT_W: desired rising-edge count per window. Latched at start.
- `cmp_in` in 1: asynchronous comparator output from the gyrator load node.
- `trim` out TRIM_W: code to the bias DAC.
- `busy` out 1: calibration in progress.
- `done` out 1: one-cycle pulse at completion.
- `locked` out 1: a completed result is valid.
- `meas` out CNT_W: edge count from the most recent window.

## Operation

- States:
  - IDLE: no activity.
  - SETTLE: wait for the analog path to settle.
  - MEASURE: count edges over the window.
  - DECIDE: resolve the current trim bit.
  - FINISH: signal completion.
- IDLE, `start`=1:
  - latch `gate_len` and `target`;
  - `trim` ← 1 followed by zeros (midscale), bit index k ← TRIM_W-1;
  - `busy` ← 1, `locked` ← 0;
  - go to SETTLE.
- SETTLE: lasts exactly SETTLE_CYC cycles, then MEASURE with the edge counter cleared.
- MEASURE:
  - lasts exactly the latched gate length in cycles;
  - counts rising edges of the 2-flop-synchronised `cmp_in`; the edge detector compares the sync output with its previous value;
  - the counter saturates at 2^CNT_W−1 with no wrap;
  - edges detected outside MEASURE are ignored.
- DECIDE, one cycle:
  - `meas` ← count;
  - if count > target, trim[k] ← 0; otherwise trim[k] stays 1 (higher trim gives higher frequency);
  - if k > 0: trim[k-1] ← 1, k ← k-1, go to SETTLE;
  - else go to FINISH.
- FINISH, one cycle: `done`=1, `busy`=0, `locked` ← 1, then IDLE.
- `start` while `busy` is ignored. `start` held high in IDLE after FINISH starts a new run.
- Reset mid-run aborts immediately; all outputs return to reset values.
- Reset values: `trim`=0, `busy`=0, `done`=0, `locked`=0, `meas`=0, state IDLE.
- Changing `gate_len` or `target` mid-run has no effect.

## Timing

- `busy` rises on the clk edge that samples `start`. `trim` shows midscale from that same edge.
- Per bit: SETTLE_CYC + G + 1 cycles, where G = max(gate_len,1).
- Total from the start-sampling edge to `done` high: TRIM_W·(SETTLE_CYC+G+1) cycles. `done` lasts one cycle; `busy` is low in that same cycle.
- `trim` changes only on the DECIDE→SETTLE and IDLE→SETTLE edges, so it is stable through each SETTLE+MEASURE.
- `meas` updates only at DECIDE and holds otherwise.
- Synchroniser latency is 2 cycles. An edge arriving on `cmp_in` within 2 cycles before the end of MEASURE may be missed; this is accepted.

## Structure

- Package `gyrator_pkg`:
  - state enum (IDLE, SETTLE, MEASURE, DECIDE, FINISH);
  - default parameter constants;
  - sync depth constant (2).
- Sub-module `gyrator_edge_cnt`:
  - synchroniser, rising-edge detect, saturating CNT_W counter;
  - `clr` and `en` inputs.
- The top level holds the FSM, SAR register, bit index and settle/gate timers.

## Test plan

- Reset mid-MEASURE (bit 3 of 6), then release → all outputs at 0, IDLE; a fresh `start` runs a full 6-bit sequence.
- Bench model: `cmp_in` period ∝ 1/(trim+1), with edges per window = trim·2. Use gate_len=64, target=40 → final trim=20, `locked`=1, `meas` = count at trim=20, `done` at 6·(16+64+1)=486 cycles after start.
- target=0, model always toggling → trim=0 after 6 bits; target=1023 → trim=63.
- gate_len=0 → window of 1 cycle; total latency 6·18=108 cycles.
- `cmp_in` toggling every cycle with gate_len=4095 → count saturates at 1023, no wrap.
- `start` pulsed during busy, and `target` changed mid-run → no restart, result uses the latched target.
